// File: rtl/output_digit_unit.sv
// output_digit_unit: sequential double-dabble binary-to-BCD converter for the seven-segment display.
// Define OUTPUT_SIGNED_EN to treat output_data as two's complement and report the sign on negative.
module output_digit_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DIGIT_CNT = 8,
    parameter int BCD_DIGITS = 10,
    parameter int DIGIT_RADIX_WIDTH = 4,
    parameter logic [DIGIT_RADIX_WIDTH-1:0] BLANK_CODE = 4'hF
) (
    input  logic clk,
    input  logic rst,
    input  logic output_enable,
    input  logic [DATA_WIDTH-1:0] output_data,
    output logic busy,
    output logic output_complete,
    output logic [DIGIT_CNT*DIGIT_RADIX_WIDTH-1:0] display_digits,
    output logic [3:0] digit_count,
    output logic overflow_9th,
    output logic overflow_10th,
    output logic negative
);
    localparam int BW = BCD_DIGITS * 4;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;
    state_t r_state;
    logic [DATA_WIDTH-1:0] r_op;
    logic [BW-1:0] r_bcd;
    logic [CW-1:0] r_cnt;
    logic r_busy, r_done, r_ovf9, r_ovf10;
    logic [DIGIT_CNT*DIGIT_RADIX_WIDTH-1:0] r_disp;
    logic [3:0] r_count;
    logic [DATA_WIDTH-1:0] w_mag;
    logic [BW-1:0] w_adj;
    logic [3:0] w_count;
    logic [DIGIT_CNT*DIGIT_RADIX_WIDTH-1:0] w_disp;
`ifdef OUTPUT_SIGNED_EN
    logic r_sign, r_neg;
    assign w_mag = output_data[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} - output_data : output_data;
    assign negative = r_neg;
`else
    assign w_mag = output_data;
    assign negative = 1'b0;
`endif
    always_comb begin
        w_count = 4'd1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            w_adj[i*4+:4] = r_bcd[i*4+:4] >= 4'd5 ? r_bcd[i*4+:4] + 4'd3 : r_bcd[i*4+:4];
            if (i > 0 && r_bcd[i*4+:4] != 4'd0) w_count = 4'(i + 1);
        end
        for (int i = 0; i < DIGIT_CNT; i++)
            w_disp[i*DIGIT_RADIX_WIDTH+:DIGIT_RADIX_WIDTH] = 4'(i) >= w_count ? BLANK_CODE : DIGIT_RADIX_WIDTH'(r_bcd[i*4+:4]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_disp <= {{(DIGIT_CNT-1){BLANK_CODE}}, DIGIT_RADIX_WIDTH'(0)};
            r_count <= 4'd1;
            r_ovf9 <= 1'b0;
            r_ovf10 <= 1'b0;
`ifdef OUTPUT_SIGNED_EN
            r_sign <= 1'b0;
            r_neg <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (output_enable) begin
                    r_op <= w_mag;
                    r_bcd <= '0;
                    r_cnt <= '0;
                    r_busy <= 1'b1;
                    r_state <= CONVERT;
`ifdef OUTPUT_SIGNED_EN
                    r_sign <= output_data[DATA_WIDTH-1];
`endif
                end
                CONVERT: begin
                    {r_bcd, r_op} <= {w_adj, r_op} << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(DATA_WIDTH - 1)) r_state <= FINISH;
                end
                FINISH: begin
                    r_disp <= w_disp;
                    r_count <= w_count;
                    r_ovf9 <= w_count >= 4'd9;
                    r_ovf10 <= w_count == 4'd10;
`ifdef OUTPUT_SIGNED_EN
                    r_neg <= r_sign;
`endif
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy = r_busy;
    assign output_complete = r_done;
    assign display_digits = r_disp;
    assign digit_count = r_count;
    assign overflow_9th = r_ovf9;
    assign overflow_10th = r_ovf10;
endmodule
